hash_table: RTL and testbench
=============================

HASH_TABLE -- requirements
Module: hash_table

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 32, key width in bits.
REQ-002 SHALL have parameter VALUE_WIDTH, default 32, value width in bits.
REQ-003 SHALL have parameter TOTAL_INDEX, default 8, number of hash buckets (power of 2).
REQ-004 SHALL have parameter CHAINING_SIZE, default 4, entries per bucket (chaining mode).
REQ-005 SHALL have parameter COLLISION_METHOD, default "MULTI_STAGE_CHAINING", other legal value "LINEAR_PROBING".
REQ-006 SHALL have parameter HASH_ALGORITHM, default "MODULUS"; any other value hashes to key_in[INDEX_WIDTH-1:0].
REQ-007 SHALL use INDEX_WIDTH=$clog2(TOTAL_INDEX) and CHAIN_WIDTH=$clog2(CHAINING_SIZE).
REQ-008 clk  input  1  sole clock; all logic on rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 key_in  input  KEY_WIDTH  operation key.
REQ-011 value_in  input  VALUE_WIDTH  insert value.
REQ-012 op_sel  input  2  00 insert, 01 delete, 10 search, 11 reserved.
REQ-013 op_en  input  1  operation request, level, held until op_done seen.
REQ-014 value_out  output  VALUE_WIDTH  search result.
REQ-015 op_done  output  1  one-cycle completion pulse.
REQ-016 op_error  output  1  insert: bucket full; delete/search: key not found; reserved op.
REQ-017 collision_count  output  CHAIN_WIDTH  entries already occupying the target bucket at op start, saturating at 2^CHAIN_WIDTH-1.

Function
REQ-018 Hash index SHALL be key_in % TOTAL_INDEX for "MODULUS".
REQ-019 Storage per slot SHALL be key, value, valid bit; chaining mode holds TOTAL_INDEX x CHAINING_SIZE slots plus per-bucket entry count.
REQ-020 FSM states SHALL be IDLE, SEARCH, INSERT, DELETE, DONE, RELEASE.
REQ-021 IDLE: op_en=1 sampled -> latch key_in, value_in, op_sel, hash index; go SEARCH.
REQ-022 SEARCH (chaining) SHALL compare one chain slot per cycle from slot 0 up to bucket count; stop on first key match or end of chain.
REQ-023 Insert with match SHALL overwrite that slot's value, op_error=0.
REQ-024 Insert without match, count<CHAINING_SIZE, SHALL append at slot[count], count+1, op_error=0.
REQ-025 Insert without match, count==CHAINING_SIZE, SHALL leave table unchanged, op_error=1.
REQ-026 Delete with match at slot i SHALL shift slots i+1..count-1 down by one (order preserved), clear last slot, count-1, op_error=0.
REQ-027 Delete/search without match SHALL leave table unchanged, op_error=1; search miss drives value_out=0.
REQ-028 Search hit SHALL drive value_out=stored value, op_error=0; insert/delete SHALL not change value_out.
REQ-029 op_sel=11 SHALL complete with op_error=1, no table change.
REQ-030 DONE SHALL assert op_done for exactly one cycle with op_error, value_out, collision_count valid in that cycle and held until next op completes.
REQ-031 RELEASE SHALL wait until op_en sampled 0, then go IDLE; an op_en held high after op_done SHALL NOT restart the operation.
REQ-032 Latency SHALL be at most CHAINING_SIZE+4 cycles from op_en sampled to op_done.
REQ-033 LINEAR_PROBING: one entry per bucket; probe index h, h+1,... modulo TOTAL_INDEX (wrap), at most TOTAL_INDEX probes; insert uses first empty/deleted slot if key absent; full table -> op_error=1; delete marks slot tombstone (skipped by search, reusable by insert); collision_count = probes before hit/free slot, saturating.
REQ-034 Inputs other than op_en SHALL be ignored outside IDLE.

Reset
REQ-035 rst=1 at a clock edge SHALL clear all valid bits, counts, tombstones, set FSM IDLE, value_out=0, op_done=0, op_error=0, collision_count=0.
REQ-036 rst SHALL take priority over any operation in progress, aborting it without op_done.

Verification
REQ-037 After reset: insert(1,2) -> op_done, op_error=0; search(1) -> value_out=2, op_error=0.
REQ-038 insert keys 3,11,19,27 (bucket 3) -> all op_error=0; insert(35,5), insert(43,5) -> op_error=1 each, collision_count=3.
REQ-039 delete(1) -> op_error=0; search(1) -> op_error=1, value_out=0; delete(1) again -> op_error=1.
REQ-040 search(19) -> value_out=4; search(3) -> value_out=2; after delete(11), search(27) -> 5 and insert(35,9) -> op_error=0.
REQ-041 insert(3,7) on existing key -> op_error=0, bucket count unchanged; search(3) -> 7.
REQ-042 op_en held high 3 cycles past op_done -> single op_done pulse; rst asserted mid-SEARCH -> no op_done, all searches then miss.

Source files
------------

// File: rtl/hash_table.sv
// Key/value hash table with an FSM that serves one insert, delete or search at a time.
// Supports multi-stage chaining (bucket of CHAINING_SIZE slots) or linear probing with tombstones.
module hash_table #(
   parameter int KEY_WIDTH        = 32,
   parameter int VALUE_WIDTH      = 32,
   parameter int TOTAL_INDEX      = 8,
   parameter int CHAINING_SIZE    = 4,
   parameter     COLLISION_METHOD = "MULTI_STAGE_CHAINING",
   parameter     HASH_ALGORITHM   = "MODULUS",
   parameter int INDEX_WIDTH      = $clog2(TOTAL_INDEX),
   parameter int CHAIN_WIDTH      = $clog2(CHAINING_SIZE)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [KEY_WIDTH-1:0]   key_in,
   input  logic [VALUE_WIDTH-1:0] value_in,
   input  logic [1:0]             op_sel,
   input  logic                   op_en,
   output logic [VALUE_WIDTH-1:0] value_out,
   output logic                   op_done,
   output logic                   op_error,
   output logic [CHAIN_WIDTH-1:0] collision_count
);
   localparam bit IS_LP  = (COLLISION_METHOD == "LINEAR_PROBING");
   localparam bit IS_MOD = (HASH_ALGORITHM == "MODULUS");
   localparam int NSLOT  = IS_LP ? TOTAL_INDEX : TOTAL_INDEX * CHAINING_SIZE;
   localparam int SW     = (NSLOT > 1) ? $clog2(NSLOT) : 1;
   localparam int LIMIT  = IS_LP ? TOTAL_INDEX : CHAINING_SIZE;
   localparam int PW     = $clog2(LIMIT + 1);
   localparam int CNTW   = $clog2(CHAINING_SIZE + 1);
   localparam int MAXC   = (1 << CHAIN_WIDTH) - 1;

   typedef enum logic [2:0] {IDLE, SEARCH, INSERT, DELETE, DONE, RELEASE} state_t;
   state_t state;

   logic [KEY_WIDTH-1:0]   slot_key  [NSLOT];
   logic [VALUE_WIDTH-1:0] slot_val  [NSLOT];
   logic                   slot_vld  [NSLOT];
   logic                   slot_tomb [NSLOT];
   logic [CNTW-1:0]        cnt       [TOTAL_INDEX];

   logic [KEY_WIDTH-1:0]   key_r;
   logic [VALUE_WIDTH-1:0] val_r;
   logic [1:0]             op_r;
   logic [INDEX_WIDTH-1:0] idx_r;
   logic [PW-1:0]          ptr, free_off, f_off;
   logic [SW-1:0]          probe, free_slot, f_slot;
   logic                   free_vld, f_vld, hit, match, s_done, s_hit;
   logic [CHAIN_WIDTH-1:0] coll_r, coll_fin;

   function automatic logic [INDEX_WIDTH-1:0] hash(input logic [KEY_WIDTH-1:0] k);
      if (IS_MOD) return INDEX_WIDTH'(k % KEY_WIDTH'(TOTAL_INDEX));
      else        return k[INDEX_WIDTH-1:0];
   endfunction

   // Chaining: bucket base + chain position. Probing: wrap-around probe offset.
   function automatic logic [SW-1:0] slot_of(input logic [INDEX_WIDTH-1:0] b, input logic [PW-1:0] p);
      if (IS_LP) return SW'((int'(b) + int'(p)) % TOTAL_INDEX);
      else       return SW'(int'(b) * CHAINING_SIZE + int'(p));
   endfunction

   function automatic logic [CHAIN_WIDTH-1:0] sat(input int v);
      return (v > MAXC) ? CHAIN_WIDTH'(MAXC) : CHAIN_WIDTH'(v);
   endfunction

   // One compare per cycle; also tracks the first reusable slot when probing.
   always_comb begin
      probe  = slot_of(idx_r, ptr);
      match  = slot_vld[probe] && (slot_key[probe] == key_r);
      s_done = 1'b0;
      s_hit  = 1'b0;
      f_vld  = free_vld;
      f_slot = free_slot;
      f_off  = free_off;
      if (IS_LP) begin
         if (ptr == PW'(LIMIT)) s_done = 1'b1;
         else if (match) begin
            s_done = 1'b1;
            s_hit  = 1'b1;
         end else if (!slot_vld[probe]) begin
            if (!free_vld) begin
               f_vld  = 1'b1;
               f_slot = probe;
               f_off  = ptr;
            end
            if (!slot_tomb[probe]) s_done = 1'b1;
         end
      end else begin
         if (int'(ptr) >= int'(cnt[idx_r])) s_done = 1'b1;
         else if (match) begin
            s_done = 1'b1;
            s_hit  = 1'b1;
         end
      end
      coll_fin = IS_LP ? sat(int'((s_hit || !f_vld) ? ptr : f_off)) : coll_r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         value_out       <= '0;
         op_done         <= 1'b0;
         op_error        <= 1'b0;
         collision_count <= '0;
         ptr             <= '0;
         free_vld        <= 1'b0;
         for (int i = 0; i < NSLOT; i++) begin
            slot_vld[SW'(i)]  <= 1'b0;
            slot_tomb[SW'(i)] <= 1'b0;
         end
         for (int i = 0; i < TOTAL_INDEX; i++) cnt[INDEX_WIDTH'(i)] <= '0;
      end else begin
         case (state)
            IDLE: begin
               op_done <= 1'b0;
               if (op_en) begin
                  key_r    <= key_in;
                  val_r    <= value_in;
                  op_r     <= op_sel;
                  idx_r    <= hash(key_in);
                  ptr      <= '0;
                  free_vld <= 1'b0;
                  coll_r   <= sat(int'(cnt[hash(key_in)]));
                  state    <= SEARCH;
               end
            end
            SEARCH: begin
               free_vld  <= f_vld;
               free_slot <= f_slot;
               free_off  <= f_off;
               if (s_done) begin
                  hit    <= s_hit;
                  coll_r <= coll_fin;
                  case (op_r)
                     2'b00: state <= INSERT;
                     2'b01: state <= DELETE;
                     2'b10: begin
                        value_out       <= s_hit ? slot_val[probe] : '0;
                        op_error        <= !s_hit;
                        collision_count <= coll_fin;
                        op_done         <= 1'b1;
                        state           <= DONE;
                     end
                     default: begin
                        op_error        <= 1'b1;
                        collision_count <= coll_fin;
                        op_done         <= 1'b1;
                        state           <= DONE;
                     end
                  endcase
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            INSERT: begin
               op_error <= 1'b0;
               if (hit) begin
                  slot_val[probe] <= val_r;
               end else if (IS_LP) begin
                  if (free_vld) begin
                     slot_key[free_slot]  <= key_r;
                     slot_val[free_slot]  <= val_r;
                     slot_vld[free_slot]  <= 1'b1;
                     slot_tomb[free_slot] <= 1'b0;
                  end else begin
                     op_error <= 1'b1;
                  end
               end else if (int'(cnt[idx_r]) < CHAINING_SIZE) begin
                  slot_key[probe] <= key_r;
                  slot_val[probe] <= val_r;
                  slot_vld[probe] <= 1'b1;
                  cnt[idx_r]      <= cnt[idx_r] + 1'b1;
               end else begin
                  op_error <= 1'b1;
               end
               collision_count <= coll_r;
               op_done         <= 1'b1;
               state           <= DONE;
            end
            DELETE: begin
               op_error <= !hit;
               if (hit) begin
                  if (IS_LP) begin
                     slot_vld[probe]  <= 1'b0;
                     slot_tomb[probe] <= 1'b1;
                  end else begin
                     // Close the gap so the chain stays dense and in insertion order.
                     for (int j = 0; j < CHAINING_SIZE; j++) begin
                        if (j >= int'(ptr) && j < int'(cnt[idx_r]) - 1) begin
                           slot_key[slot_of(idx_r, PW'(j))] <= slot_key[slot_of(idx_r, PW'(j + 1))];
                           slot_val[slot_of(idx_r, PW'(j))] <= slot_val[slot_of(idx_r, PW'(j + 1))];
                        end
                        if (j == int'(cnt[idx_r]) - 1) slot_vld[slot_of(idx_r, PW'(j))] <= 1'b0;
                     end
                     cnt[idx_r] <= cnt[idx_r] - 1'b1;
                  end
               end
               collision_count <= coll_r;
               op_done         <= 1'b1;
               state           <= DONE;
            end
            DONE: begin
               op_done <= 1'b0;
               state   <= RELEASE;
            end
            RELEASE: if (!op_en) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hash_table.sv
// Randomized and directed bench for hash_table (default chaining config) against a
// bucket-of-queues reference model.
module tb_hash_table;
   localparam int TI = 8;
   localparam int CS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] key_in, value_in;
   logic [1:0]  op_sel;
   logic        op_en;
   logic [31:0] value_out;
   logic        op_done, op_error;
   logic [1:0]  collision_count;

   hash_table dut (
      .clk(clk), .rst(rst), .key_in(key_in), .value_in(value_in), .op_sel(op_sel),
      .op_en(op_en), .value_out(value_out), .op_done(op_done), .op_error(op_error),
      .collision_count(collision_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model: each bucket is an ordered list of (key, value)
   logic [31:0] bk_key [TI][$];
   logic [31:0] bk_val [TI][$];
   logic [31:0] m_vo;

   logic [31:0] pend_vo, hold_vo;
   logic        pend_err, hold_err;
   logic [1:0]  pend_cc, hold_cc;
   logic        chk_en = 1'b0;

   task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < TI; b++) begin
         bk_key[b].delete();
         bk_val[b].delete();
      end
      m_vo = 32'd0;
   endtask

   task automatic model_op(input logic [1:0] op, input logic [31:0] k, input logic [31:0] v);
      int b, n, pos;
      b   = int'(k % TI);
      n   = bk_key[b].size();
      pos = -1;
      for (int i = 0; i < n; i++) if (pos < 0 && bk_key[b][i] == k) pos = i;
      pend_cc  = (n > 3) ? 2'd3 : 2'(n);
      pend_err = 1'b0;
      case (op)
         2'd0: if (pos >= 0) bk_val[b][pos] = v;
               else if (n < CS) begin bk_key[b].push_back(k); bk_val[b].push_back(v); end
               else pend_err = 1'b1;
         2'd1: if (pos >= 0) begin bk_key[b].delete(pos); bk_val[b].delete(pos); end
               else pend_err = 1'b1;
         2'd2: if (pos >= 0) m_vo = bk_val[b][pos];
               else begin m_vo = 32'd0; pend_err = 1'b1; end
         default: pend_err = 1'b1;
      endcase
      pend_vo = m_vo;
   endtask

   // Outputs are meaningful every cycle: fresh on op_done, held otherwise.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         if (op_done) begin
            cmp("done_value_out", value_out, pend_vo);
            cmp("done_op_error", 32'(op_error), 32'(pend_err));
            cmp("done_collision_count", 32'(collision_count), 32'(pend_cc));
            hold_vo = pend_vo; hold_err = pend_err; hold_cc = pend_cc;
         end else begin
            cmp("held_value_out", value_out, hold_vo);
            cmp("held_op_error", 32'(op_error), 32'(hold_err));
            cmp("held_collision_count", 32'(collision_count), 32'(hold_cc));
         end
      end
   end

   task automatic do_op(input logic [1:0] op, input logic [31:0] k, input logic [31:0] v,
                        input int hold_cyc, output logic [31:0] g_vo, output logic g_err,
                        output logic [1:0] g_cc);
      int n, pulses;
      bit seen;
      model_op(op, k, v);
      @(negedge clk);
      op_sel = op; key_in = k; value_in = v; op_en = 1'b1;
      n = 0; seen = 0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (op_done) seen = 1;
         // inputs other than op_en must be ignored once the op is latched
         if (n == 1) begin
            key_in = $urandom; value_in = $urandom; op_sel = 2'($urandom);
         end
      end
      cmp("op_done_seen", 32'(seen), 32'd1);
      cmp("latency_bound", 32'(n <= CS + 4), 32'd1);
      g_vo = value_out; g_err = op_error; g_cc = collision_count;
      pulses = seen ? 1 : 0;
      repeat (hold_cyc) begin
         @(negedge clk);
         if (op_done) pulses++;
      end
      op_en = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (op_done) pulses++;
      end
      cmp("single_done_pulse", 32'(pulses), 32'd1);
   endtask

   logic [31:0] vo;
   logic        er;
   logic [1:0]  cc;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; op_en = 1'b0; op_sel = 2'd0; key_in = '0; value_in = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cmp("reset_value_out", value_out, 32'd0);
      cmp("reset_op_done", 32'(op_done), 32'd0);
      cmp("reset_op_error", 32'(op_error), 32'd0);
      cmp("reset_collision_count", 32'(collision_count), 32'd0);
      hold_vo = 0; hold_err = 0; hold_cc = 0;
      chk_en = 1'b1;

      do_op(2'd0, 1, 2, 0, vo, er, cc);  cmp("ins_1_err", 32'(er), 0);
      do_op(2'd2, 1, 0, 0, vo, er, cc);  cmp("srch_1_val", vo, 2); cmp("srch_1_err", 32'(er), 0);

      do_op(2'd0, 3, 2, 0, vo, er, cc);  cmp("ins_3_err", 32'(er), 0);
      do_op(2'd0, 11, 3, 0, vo, er, cc); cmp("ins_11_cc", 32'(cc), 1);
      do_op(2'd0, 19, 4, 0, vo, er, cc); cmp("ins_19_err", 32'(er), 0);
      do_op(2'd0, 27, 5, 0, vo, er, cc); cmp("ins_27_err", 32'(er), 0);
      do_op(2'd0, 35, 5, 0, vo, er, cc); cmp("ins_35_full_err", 32'(er), 1); cmp("ins_35_cc", 32'(cc), 3);
      do_op(2'd0, 43, 5, 0, vo, er, cc); cmp("ins_43_full_err", 32'(er), 1); cmp("ins_43_cc", 32'(cc), 3);

      do_op(2'd1, 1, 0, 0, vo, er, cc);  cmp("del_1_err", 32'(er), 0);
      do_op(2'd2, 1, 0, 0, vo, er, cc);  cmp("srch_1_miss_err", 32'(er), 1); cmp("srch_1_miss_val", vo, 0);
      do_op(2'd1, 1, 0, 0, vo, er, cc);  cmp("del_1_again_err", 32'(er), 1);

      do_op(2'd2, 19, 0, 0, vo, er, cc); cmp("srch_19_val", vo, 4);
      do_op(2'd2, 3, 0, 0, vo, er, cc);  cmp("srch_3_val", vo, 2);
      do_op(2'd1, 11, 0, 0, vo, er, cc); cmp("del_11_err", 32'(er), 0);
      do_op(2'd2, 27, 0, 0, vo, er, cc); cmp("srch_27_after_shift", vo, 5);
      do_op(2'd0, 35, 9, 0, vo, er, cc); cmp("ins_35_err", 32'(er), 0);

      do_op(2'd0, 3, 7, 0, vo, er, cc);  cmp("ovw_3_err", 32'(er), 0);
      do_op(2'd2, 3, 0, 0, vo, er, cc);  cmp("srch_3_new_val", vo, 7);
      do_op(2'd0, 51, 1, 0, vo, er, cc); cmp("bucket3_still_full", 32'(er), 1);
      do_op(2'd3, 5, 0, 0, vo, er, cc);  cmp("reserved_err", 32'(er), 1);
      do_op(2'd2, 35, 0, 3, vo, er, cc); cmp("held_en_srch_35", vo, 9);

      // reset while the search walks bucket 3
      chk_en = 1'b0;
      @(negedge clk);
      key_in = 35; op_sel = 2'd2; op_en = 1'b1;
      repeat (2) begin @(negedge clk); cmp("no_done_before_rst", 32'(op_done), 0); end
      rst = 1'b1; op_en = 1'b0;
      repeat (2) begin @(negedge clk); cmp("no_done_in_rst", 32'(op_done), 0); end
      rst = 1'b0;
      repeat (4) begin @(negedge clk); cmp("no_done_after_rst", 32'(op_done), 0); end
      cmp("rst_mid_value_out", value_out, 0);
      cmp("rst_mid_collision_count", 32'(collision_count), 0);
      model_reset();
      hold_vo = 0; hold_err = 0; hold_cc = 0;
      chk_en = 1'b1;
      do_op(2'd2, 35, 0, 0, vo, er, cc); cmp("post_rst_35_miss", 32'(er), 1);
      do_op(2'd2, 3, 0, 0, vo, er, cc);  cmp("post_rst_3_miss", 32'(er), 1);
      do_op(2'd2, 19, 0, 0, vo, er, cc); cmp("post_rst_19_miss", 32'(er), 1);
      do_op(2'd2, 27, 0, 0, vo, er, cc); cmp("post_rst_27_miss", 32'(er), 1);

      // random traffic over a small key space so buckets fill, shift and overflow
      for (int t = 0; t < 250; t++) begin
         int sel;
         logic [1:0] op;
         sel = $urandom_range(0, 9);
         op  = (sel < 4) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
         do_op(op, 32'($urandom_range(0, 47)), $urandom, (t % 17 == 0) ? 2 : 0, vo, er, cc);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
